cpu_mem_loader: RTL
===================

// Module: cpu_mem_loader
// PURPOSE
//  Host-side initiator for the cpu external memory ports. Loads a program into instruction memory and data into data memory.
//  Runs the cpu for a programmed number of cycles, then streams a range of data memory back out to the host.
//  Sits between the testbench/host link and the cpu top; it is the only driver of addr_ext*, wen_ext*, ren_ext* and enable.
// PARAMETERS
//  IMEM_DEPTH  512   instruction memory depth in 32-bit words (byte stride 4)
//  DMEM_DEPTH  1024  data memory depth in 64-bit words (byte stride 8)
//  RUN_W       32    width of the run-cycle counter
// PORTS
//  clk          in   1   single clock, rising edge
//  arst         in   1   asynchronous reset, active-high
//  start        in   1   1-cycle pulse; latches n_imem/n_dmem/run_cycles/n_dump; ignored unless IDLE
//  n_imem       in   10  instruction words to load
//  n_dmem       in   11  data words to load
//  run_cycles   in   RUN_W  cycles with cpu enable high
//  n_dump       in   11  data words to read back from address 0
//  s_valid      in   1   host write stream valid
//  s_ready      out  1   host write stream ready
//  s_data       in   64  host write word (IMEM phase uses [31:0])
//  m_valid      out  1   dump stream valid
//  m_ready      in   1   dump stream ready
//  m_data       out  64  dump word
//  cpu_enable   out  1   to cpu enable
//  addr_ext     out  64  IMEM byte address;   wen_ext out 1; ren_ext out 1 (always 0); wdata_ext out 32
//  addr_ext_2   out  64  DMEM byte address;   wen_ext_2 out 1; ren_ext_2 out 1; wdata_ext_2 out 64
//  rdata_ext_2  in   64  DMEM read data, valid 1 cycle after ren_ext_2
//  busy         out  1   high in every state except IDLE
//  done         out  1   high from end of dump until next accepted start
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-operation aborts immediately; memory contents are not restored.
//  - FSM: IDLE -> LOAD_I -> LOAD_D -> RUN -> DUMP_RD -> DUMP_CAP -> DUMP_OUT -> (DUMP_RD | FIN) -> IDLE.
//  - Counts are latched at start and saturate: n_imem>IMEM_DEPTH -> IMEM_DEPTH; n_dmem/n_dump>DMEM_DEPTH -> DMEM_DEPTH.
//  - A zero count (or run_cycles==0) skips its phase in 0 cycles; the FSM goes straight to the next non-empty phase.
//  - LOAD_I: s_ready=1. On s_valid&s_ready: wen_ext=1, addr_ext=4*idx, wdata_ext=s_data[31:0], idx++.
//    The last word moves to LOAD_D with idx cleared. No write on cycles where s_valid=0.
//  - LOAD_D: same handshake, with wen_ext_2, addr_ext_2=8*idx, wdata_ext_2=s_data.
//  - s_ready=0 in all other states. Write strobes are combinational on the handshake, so a write is 0-latency.
//  - RUN: cpu_enable=1 for exactly run_cycles consecutive cycles; all ext strobes 0. cpu_enable=0 in every other state.
//  - DUMP_RD: ren_ext_2=1, addr_ext_2=8*idx (1 cycle).
//  - DUMP_CAP: m_data <= rdata_ext_2.
//  - DUMP_OUT: m_valid=1 and m_data held stable until m_ready. On acceptance: idx++, then DUMP_RD, or FIN after the last word.
//  - Dump throughput: at most 1 word per 3 cycles.
//  - FIN: done<=1 for one cycle before the return to IDLE. done stays high in IDLE and clears when the next start is accepted.
//  - Invariants: cpu_enable and any ext strobe are never high together. wen_ext_2 and ren_ext_2 are never high together.
//  - start during busy has no effect. Address arithmetic is idx zero-extended to 64 bits, shifted left 2 (IMEM) or 3 (DMEM).
// STRUCTURE
//  - Shared package/header cpu_loader_pkg: state encoding (3-bit localparams), IMEM/DMEM stride shift constants (2, 3), count widths.
//  - One sub-module: loader_idx_counter (clear, inc, saturating target compare, last flag).
//    It is reused for the load/dump index; a separate RUN_W down-counter handles RUN.
//  - Everything else is a single FSM plus output registers in this module.
// TESTING
//  1. Reset mid-LOAD_I (after 2 of 5 words): all outputs 0 next cycle. A later start with n_imem=3 writes addrs 0,4,8 only.
//  2. n_imem=4, n_dmem=2, s_valid toggling 1010...: wen_ext at addrs 0,4,8,12, then wen_ext_2 at 0,8; no strobe when s_valid=0.
//  3. run_cycles=7: cpu_enable high exactly 7 cycles, all ext strobes 0 throughout; run_cycles=0 goes LOAD_D -> DUMP_RD directly.
//  4. DMEM model returns 64'hA0+idx, n_dump=3, m_ready low for 5 cycles on word 1:
//     m_data 0xA0,0xA1,0xA2 in order; m_data stable while stalled; done rises after word 2.
//  5. All counts 0: start -> done within 2 cycles, no strobes, cpu_enable never asserted.
//  6. n_dump=2000: exactly 1024 words dumped, last addr_ext_2=0x1FF8. start pulsed while busy: no effect.

Source files
------------

// File: rtl/cpu_mem_loader_pkg.sv
// cpu_mem_loader_pkg: shared state encoding, depths, widths and phase-skip helpers for the memory loader
package cpu_mem_loader_pkg;

    localparam int IMEM_DEPTH = 512;
    localparam int DMEM_DEPTH = 1024;
    localparam int RUN_W      = 32;
    localparam int IMEM_CNT_W = 10;
    localparam int IDX_W      = 11;
    localparam int IMEM_SHIFT = 2;
    localparam int DMEM_SHIFT = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_I   = 3'd1,
        LOAD_D   = 3'd2,
        RUN      = 3'd3,
        DUMP_RD  = 3'd4,
        DUMP_CAP = 3'd5,
        DUMP_OUT = 3'd6,
        FIN      = 3'd7
    } state_t;

    // One flag per phase: set when that phase has work to do
    typedef struct packed {
        logic dump;
        logic run;
        logic dmem;
        logic imem;
    } nz_t;

    function automatic logic [IDX_W-1:0] sat_cnt(input logic [IDX_W-1:0] n, input logic [IDX_W-1:0] lim);
        return (n > lim) ? lim : n;
    endfunction

    // First phase at or after 'from' that has a non-zero count; empty phases take no cycles
    function automatic state_t first_phase(input state_t from, input nz_t nz);
        return (from <= LOAD_I  && nz.imem) ? LOAD_I  :
               (from <= LOAD_D  && nz.dmem) ? LOAD_D  :
               (from <= RUN     && nz.run ) ? RUN     :
               (from <= DUMP_RD && nz.dump) ? DUMP_RD : FIN;
    endfunction

endpackage

// File: rtl/cpu_mem_loader_if.sv
// cpu_mem_loader_if: host stream, dump stream, control and cpu external memory port bundle
interface cpu_mem_loader_if;

    logic                                start;
    logic [9:0]                          n_imem;
    logic [10:0]                         n_dmem;
    logic [cpu_mem_loader_pkg::RUN_W-1:0] run_cycles;
    logic [10:0]                         n_dump;
    logic                                s_valid;
    logic                                s_ready;
    logic [63:0]                         s_data;
    logic                                m_valid;
    logic                                m_ready;
    logic [63:0]                         m_data;
    logic                                cpu_enable;
    logic [63:0]                         addr_ext;
    logic                                wen_ext;
    logic                                ren_ext;
    logic [31:0]                         wdata_ext;
    logic [63:0]                         addr_ext_2;
    logic                                wen_ext_2;
    logic                                ren_ext_2;
    logic [63:0]                         wdata_ext_2;
    logic [63:0]                         rdata_ext_2;
    logic                                busy;
    logic                                done;

    modport master (
        input  start, n_imem, n_dmem, run_cycles, n_dump, s_valid, s_data, m_ready, rdata_ext_2,
        output s_ready, m_valid, m_data, cpu_enable, addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done
    );

    modport slave (
        output start, n_imem, n_dmem, run_cycles, n_dump, s_valid, s_data, m_ready, rdata_ext_2,
        input  s_ready, m_valid, m_data, cpu_enable, addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done
    );

endinterface

// File: rtl/cpu_mem_loader_idx_counter.sv
// cpu_mem_loader_idx_counter: word index for load and dump phases with a last-word flag against the phase target
module cpu_mem_loader_idx_counter
    import cpu_mem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             inc,
    input  logic [IDX_W-1:0] target,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] idx_q, idx_d;

    // Clear wins over increment so the final word of a phase restarts the index at 0
    always_comb begin
        idx_d = clr ? '0 : inc ? idx_q + IDX_W'(1) : idx_q;
    end

    // Index register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) idx_q <= '0;
        else      idx_q <= idx_d;
    end

    assign idx  = idx_q;
    assign last = (idx_q + IDX_W'(1)) >= target;

endmodule

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: loads IMEM/DMEM from a host stream, runs the cpu, then streams DMEM back to the host
module cpu_mem_loader
    import cpu_mem_loader_pkg::*;
(
    input logic              clk,
    input logic              arst,
    cpu_mem_loader_if.master bus
);

    state_t                state_q, state_d;
    logic [IMEM_CNT_W-1:0] n_imem_q, n_imem_d;
    logic [IDX_W-1:0]      n_dmem_q, n_dmem_d;
    logic [IDX_W-1:0]      n_dump_q, n_dump_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [63:0]           m_data_q, m_data_d;
    logic                  done_q, done_d;
    logic [IDX_W-1:0]      idx, target;
    logic                  last, idx_clr, idx_inc, hs;
    nz_t                   nz_q, nz_in;

    assign nz_q   = {n_dump_q != '0, run_q != '0, n_dmem_q != '0, n_imem_q != '0};
    assign nz_in  = {bus.n_dump != '0, bus.run_cycles != '0, bus.n_dmem != '0, bus.n_imem != '0};
    assign hs     = bus.s_valid && bus.s_ready;
    assign target = (state_q == LOAD_I) ? IDX_W'(n_imem_q) : (state_q == LOAD_D) ? n_dmem_q : n_dump_q;

    cpu_mem_loader_idx_counter u_idx (
        .clk    (clk),
        .arst   (arst),
        .clr    (idx_clr),
        .inc    (idx_inc),
        .target (target),
        .idx    (idx),
        .last   (last)
    );

    // Sequencer: next state, latched counts, run countdown, dump capture and done flag
    always_comb begin
        state_d  = state_q;
        n_imem_d = n_imem_q;
        n_dmem_d = n_dmem_q;
        n_dump_d = n_dump_q;
        run_d    = run_q;
        m_data_d = m_data_q;
        done_d   = done_q;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_imem_d = IMEM_CNT_W'(sat_cnt(IDX_W'(bus.n_imem), IDX_W'(IMEM_DEPTH)));
                    n_dmem_d = sat_cnt(bus.n_dmem, IDX_W'(DMEM_DEPTH));
                    n_dump_d = sat_cnt(bus.n_dump, IDX_W'(DMEM_DEPTH));
                    run_d    = bus.run_cycles;
                    done_d   = 1'b0;
                    idx_clr  = 1'b1;
                    state_d  = first_phase(LOAD_I, nz_in);
                end
            end
            LOAD_I, LOAD_D: begin
                idx_inc = hs;
                if (hs && last) begin
                    idx_clr = 1'b1;
                    state_d = first_phase((state_q == LOAD_I) ? LOAD_D : RUN, nz_q);
                end
            end
            RUN: begin
                run_d   = run_q - RUN_W'(1);
                state_d = (run_q == RUN_W'(1)) ? first_phase(DUMP_RD, nz_q) : RUN;
            end
            DUMP_RD:  state_d = DUMP_CAP;
            DUMP_CAP: begin
                m_data_d = bus.rdata_ext_2;
                state_d  = DUMP_OUT;
            end
            DUMP_OUT: begin
                idx_inc = bus.m_ready;
                idx_clr = bus.m_ready && last;
                state_d = !bus.m_ready ? DUMP_OUT : last ? FIN : DUMP_RD;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            n_imem_q <= '0;
            n_dmem_q <= '0;
            n_dump_q <= '0;
            run_q    <= '0;
            m_data_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_imem_q <= n_imem_d;
            n_dmem_q <= n_dmem_d;
            n_dump_q <= n_dump_d;
            run_q    <= run_d;
            m_data_q <= m_data_d;
            done_q   <= done_d;
        end
    end

    // Write strobes follow the handshake in the same cycle; everything else decodes the state register
    assign bus.s_ready     = (state_q == LOAD_I) || (state_q == LOAD_D);
    assign bus.wen_ext     = (state_q == LOAD_I) && bus.s_valid;
    assign bus.addr_ext    = (state_q == LOAD_I) ? 64'(idx) << IMEM_SHIFT : '0;
    assign bus.wdata_ext   = (state_q == LOAD_I) ? bus.s_data[31:0] : '0;
    assign bus.ren_ext     = 1'b0;
    assign bus.wen_ext_2   = (state_q == LOAD_D) && bus.s_valid;
    assign bus.ren_ext_2   = (state_q == DUMP_RD);
    assign bus.addr_ext_2  = (state_q == LOAD_D || state_q == DUMP_RD) ? 64'(idx) << DMEM_SHIFT : '0;
    assign bus.wdata_ext_2 = (state_q == LOAD_D) ? bus.s_data : '0;
    assign bus.cpu_enable  = (state_q == RUN);
    assign bus.m_valid     = (state_q == DUMP_OUT);
    assign bus.m_data      = m_data_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;

endmodule
